// File: rtl/adc_fill_pkg.sv
// adc_fill_pkg: shared state encoding and default widths for the ADC fill sequencer
package adc_fill_pkg;
  localparam int FILL_W_DEF = 24;
  localparam int WIN_W_DEF  = 16;
  localparam int MISS_W_DEF = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACQUIRE = 2'd2,
    READOUT = 2'd3
  } state_t;
endpackage

// File: rtl/adc_fill_num_reg.sv
// adc_fill_num_reg: fill-number counter with load (priority) and wrapping increment
// Ports: clk, rst_n (async active-low), load/load_val load a new value, inc advances by one, cnt is the current value.
module adc_fill_num_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : inc ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/adc_fill_sequencer.sv
// adc_fill_sequencer: run-level controller opening ADC windows on triggers and handing fills to readout
// Ports: clk, rst_n (async active-low); run_start/run_stop run control; initial_fill_num, window_len, trigger stimulus;
// adc_acquire window strobe; fill_valid/fill_num/fill_ready readout handshake; busy, running, missed_triggers status.
module adc_fill_sequencer import adc_fill_pkg::*; #(
  parameter int FILL_W = FILL_W_DEF,
  parameter int WIN_W  = WIN_W_DEF,
  parameter int MISS_W = MISS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_start,
  input  logic              run_stop,
  input  logic [FILL_W-1:0] initial_fill_num,
  input  logic [WIN_W-1:0]  window_len,
  input  logic              trigger,
  output logic              adc_acquire,
  output logic              fill_valid,
  output logic [FILL_W-1:0] fill_num,
  input  logic              fill_ready,
  output logic              busy,
  output logic              running,
  output logic [MISS_W-1:0] missed_triggers
);
  state_t             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [FILL_W-1:0]  num_q, num_d, fill_cnt;
  logic               stop_q, stop_d, load, inc, in_fill;
  logic               adc_acquire_q, adc_acquire_d, fill_valid_q, fill_valid_d;
  logic               busy_q, busy_d, running_q, running_d;

  adc_fill_num_reg #(.W(FILL_W)) u_num (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (initial_fill_num),
    .inc      (inc),
    .cnt      (fill_cnt)
  );

  assign in_fill = state_q == ACQUIRE || state_q == READOUT;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    num_d   = num_q;
    load    = 1'b0;
    inc     = 1'b0;
    miss_d  = (in_fill && trigger && miss_q != '1) ? miss_q + MISS_W'(1) : miss_q;
    stop_d  = stop_q | (in_fill & run_stop);
    unique case (state_q)
      IDLE: if (run_start && !run_stop) begin
        load    = 1'b1;
        miss_d  = '0;
        state_d = ARMED;
      end
      ARMED: if (run_stop) state_d = IDLE;
      else if (trigger) begin
        win_d   = (window_len == '0) ? WIN_W'(1) : window_len;
        num_d   = fill_cnt;
        state_d = ACQUIRE;
      end
      ACQUIRE: begin
        win_d   = win_q - WIN_W'(1);
        state_d = (win_q == WIN_W'(1)) ? READOUT : ACQUIRE;
      end
      READOUT: if (fill_ready) begin
        inc     = 1'b1;
        // a stop arriving in the handshake cycle itself still ends the run
        state_d = (stop_q || run_stop) ? IDLE : ARMED;
      end
    endcase
    if (state_d == IDLE) stop_d = 1'b0;
    adc_acquire_d = state_d == ACQUIRE;
    fill_valid_d  = state_d == READOUT;
    busy_d        = state_d == ACQUIRE || state_d == READOUT;
    running_d     = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= IDLE;
      win_q         <= '0;
      miss_q        <= '0;
      num_q         <= '0;
      stop_q        <= 1'b0;
      adc_acquire_q <= 1'b0;
      fill_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      miss_q        <= miss_d;
      num_q         <= num_d;
      stop_q        <= stop_d;
      adc_acquire_q <= adc_acquire_d;
      fill_valid_q  <= fill_valid_d;
      busy_q        <= busy_d;
      running_q     <= running_d;
    end

  assign adc_acquire     = adc_acquire_q;
  assign fill_valid      = fill_valid_q;
  assign fill_num        = num_q;
  assign busy            = busy_q;
  assign running         = running_q;
  assign missed_triggers = miss_q;
endmodule

// File: doc/adc_fill_sequencer.md
# adc_fill_sequencer

Run-level controller for one ADC channel's fill acquisition. It arms on run start and opens an acquisition window of programmable length on each accepted trigger. Each completed fill is handed to the readout logic with its fill number through a valid/ready handshake. It owns the fill-number counter and advances it exactly once per fill that the readout accepts.

## Interface
Parameters:
- FILL_W, 24, fill-number width
- WIN_W, 16, acquisition-window length width
- MISS_W, 16, missed-trigger counter width

Ports:
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- run_start  input  1  single-cycle pulse; starts a run, loads initial_fill_num, clears missed_triggers
- run_stop  input  1  single-cycle pulse; ends the run after any fill in progress
- initial_fill_num  input  FILL_W  first fill number of the run, sampled on an accepted run_start
- window_len  input  WIN_W  acquisition length in clk cycles, sampled on an accepted trigger; 0 is treated as 1
- trigger  input  1  fill trigger, level-sampled each cycle
- adc_acquire  output  1  high while the ADC window is open
- fill_valid  output  1  completed fill is awaiting readout
- fill_num  output  FILL_W  number of the presented fill; stable while fill_valid is high
- fill_ready  input  1  readout accepts the fill when fill_valid and fill_ready are both high
- busy  output  1  high in ACQUIRE or READOUT
- running  output  1  high in any state except IDLE
- missed_triggers  output  MISS_W  count of triggers that arrived during ACQUIRE or READOUT

All inputs are synchronous to clk. Synchronisation is the caller's responsibility.

## Operation
- States: IDLE, ARMED, ACQUIRE, READOUT.
- IDLE:
  - Triggers are ignored and not counted.
  - run_start alone: fill_cnt <= initial_fill_num, missed_triggers <= 0, go to ARMED.
  - run_start together with run_stop: stay in IDLE, no load.
  - run_stop alone: no effect.
- ARMED:
  - run_stop: go to IDLE; run_stop wins over a trigger in the same cycle.
  - Otherwise, trigger: win_cnt <= max(window_len,1), fill_tag <= fill_cnt, go to ACQUIRE.
- ACQUIRE:
  - adc_acquire is high; win_cnt decrements each cycle.
  - When win_cnt == 1, go to READOUT.
- READOUT:
  - fill_valid is high and fill_num = fill_tag.
  - On handshake: fill_cnt <= fill_cnt + 1, wrapping 2^FILL_W-1 -> 0. Then go to ARMED, or to IDLE if stop_pending.
- run_stop in ACQUIRE or READOUT sets stop_pending. The current fill completes normally. stop_pending clears on entry to IDLE.
- run_start outside IDLE is ignored.
- A trigger in ACQUIRE or READOUT increments missed_triggers, saturating at all-ones. It never starts a fill.
- fill_cnt never changes except on an accepted run_start or a handshake.

## Timing
- Reset values (asynchronous):
  - State IDLE; adc_acquire, fill_valid, busy, running = 0; fill_num, missed_triggers, fill_cnt, stop_pending = 0.
  - Assertion mid-fill aborts immediately and no handshake completes.
- All outputs are registered.
- Fill timeline, trigger sampled in ARMED at cycle T with window N:
  - adc_acquire is high in cycles T+1 .. T+N.
  - fill_valid rises at T+N+1.
  - If fill_ready is already high, the handshake occurs at T+N+1 and the block is back in ARMED at T+N+2.
  - The earliest next accepted trigger is at T+N+2.
- Minimum fill period is N+2 cycles.
- fill_valid and fill_num hold until the handshake. The ready path has no timeout.
- A trigger held high across multiple cycles is sampled every cycle. A trigger still high on return to ARMED starts a new fill.

## Structure
- Shared package adc_fill_pkg holds:
  - the state enum (IDLE=0, ARMED=1, ACQUIRE=2, READOUT=3);
  - FILL_W, WIN_W, MISS_W defaults.
- Sub-module adc_fill_num_reg is the FILL_W load/increment counter:
  - inputs load, load_val, inc;
  - load has priority over inc.
- The FSM, window counter and miss counter live in the top.

## Test plan
- Basic fill:
  - Stimulus: run_start with initial_fill_num = 100, window_len = 4, fill_ready tied high, trigger pulse at T.
  - Required: adc_acquire high for exactly 4 cycles; fill_valid is a 1-cycle pulse at T+5 with fill_num = 100.
  - Then a second trigger gives fill_num = 101.
- Backpressure and missed triggers:
  - Stimulus: fill_ready low for 10 cycles after fill_valid; 3 trigger pulses during ACQUIRE/READOUT.
  - Required: fill_num stable throughout; missed_triggers = 3; fill_cnt advances once only after fill_ready rises.
- Wrap and window edge:
  - Stimulus: initial_fill_num = 24'hFFFFFF, two fills, window_len = 0.
  - Required: fill_num values 24'hFFFFFF then 0; adc_acquire high for 1 cycle per fill.
- Stop behaviour:
  - run_stop during ACQUIRE: the fill completes and is handed off, then IDLE; later triggers are ignored and missed_triggers is unchanged.
  - run_stop with trigger in ARMED: no fill starts.
- Async reset mid-READOUT:
  - Stimulus: drop rst_n between clock edges.
  - Required: all outputs 0 immediately.
  - Then a new run_start with initial_fill_num = 7 gives first fill_num = 7.
- Miss saturation:
  - Stimulus: MISS_W = 2, 5 missed triggers.
  - Required: missed_triggers = 3.
